// File: rtl/skid_buf2.sv
// Two-entry circular buffer with 1-bit read/write pointers and an occupancy count.
// Pointers reset on rst or clear; the data storage itself is never reset.
module skid_buf2 #(
    parameter int DWIDTH = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_clr,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DWIDTH-1:0] i_din,
    output logic [DWIDTH-1:0] o_dout,
    output logic [1:0]        o_count,
    output logic [1:0]        o_count_next
);

    logic [DWIDTH-1:0] r_mem [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;
    logic [1:0]        w_count_next;

    assign w_count_next = r_count + {1'b0, i_push} - {1'b0, i_pop};
    assign o_count      = r_count;
    assign o_count_next = w_count_next;
    assign o_dout       = r_mem[r_rd_ptr];

    // Data is captured only on push, so X on the input while idle never lands in storage.
    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr) begin
            r_count  <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
        end else begin
            r_count <= w_count_next;
            if (i_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (i_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
        end
    end

endmodule

// File: rtl/fifo_stream_writer.sv
// Valid/ready stream to FIFO write-port adapter with a registered s_ready.
// A 2-entry skid buffer absorbs the in-flight beat when fifo_full back-pressures.
module fifo_stream_writer #(
    parameter int DWIDTH    = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_wr,
    input  logic                 rst_wr_n,
    input  logic                 flush,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DWIDTH-1:0]    s_data,
    output logic [DWIDTH-1:0]    fifo_din,
    output logic                 fifo_write,
    input  logic                 fifo_full,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] wr_count
);

    localparam logic [1:0] ENTRIES = 2'd2;

    logic                 r_s_ready;
    logic [CNT_WIDTH-1:0] r_wr_count;
    logic                 w_push;
    logic                 w_pop;
    logic [1:0]           w_count;
    logic [1:0]           w_count_next;

    assign w_push = s_valid & r_s_ready;
    // Pop ignores reset so a write already presented in the reset cycle still reaches the FIFO.
    assign w_pop  = (w_count != 2'd0) & ~fifo_full & ~flush;

    skid_buf2 #(
        .DWIDTH(DWIDTH)
    ) u_buf (
        .i_clk       (clk_wr),
        .i_rst_n     (rst_wr_n),
        .i_clr       (flush),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_din       (s_data),
        .o_dout      (fifo_din),
        .o_count     (w_count),
        .o_count_next(w_count_next)
    );

    always_ff @(posedge clk_wr) begin
        if (!rst_wr_n) begin
            r_s_ready  <= 1'b0;
            r_wr_count <= '0;
        end else begin
            r_s_ready <= (w_count_next < ENTRIES) & ~flush;
            if (w_pop) begin
                r_wr_count <= r_wr_count + 1'b1;
            end
        end
    end

    assign s_ready    = r_s_ready;
    assign fifo_write = w_pop;
    assign busy       = (w_count != 2'd0);
    assign wr_count   = r_wr_count;

endmodule

// File: tb/tb_fifo_stream_writer.sv
// Directed vector table plus reset and randomized scoreboard sequences for fifo_stream_writer.
// A second instance with a 4-bit counter shares all inputs to check counter wrap.
module tb_fifo_stream_writer;

    logic        clk_wr = 1'b0;
    logic        rst_wr_n;
    logic        flush;
    logic        s_valid;
    logic [31:0] s_data;
    logic        fifo_full;
    logic        s_ready,    s_ready_n;
    logic [31:0] fifo_din,   fifo_din_n;
    logic        fifo_write, fifo_write_n;
    logic        busy,       busy_n;
    logic [15:0] wr_count;
    logic [3:0]  wr_count_n;

    int unsigned nvec  = 0;
    int unsigned nfail = 0;

    always #5 clk_wr = ~clk_wr;

    fifo_stream_writer #(.DWIDTH(32), .CNT_WIDTH(16)) dut (
        .clk_wr(clk_wr), .rst_wr_n(rst_wr_n), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .fifo_din(fifo_din), .fifo_write(fifo_write), .fifo_full(fifo_full),
        .busy(busy), .wr_count(wr_count)
    );

    fifo_stream_writer #(.DWIDTH(32), .CNT_WIDTH(4)) dut_n (
        .clk_wr(clk_wr), .rst_wr_n(rst_wr_n), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready_n), .s_data(s_data),
        .fifo_din(fifo_din_n), .fifo_write(fifo_write_n), .fifo_full(fifo_full),
        .busy(busy_n), .wr_count(wr_count_n)
    );

    typedef struct {
        logic        fl;
        logic        v;
        logic [31:0] d;
        logic        full;
        logic        e_rdy;
        logic        e_wr;
        logic        din_chk;
        logic [31:0] e_din;
        logic        e_busy;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic fl, logic v, logic [31:0] d, logic full,
                                logic rdy, logic wr, logic dc, logic [31:0] din,
                                logic bsy, logic [15:0] cnt);
        vec_t r;
        r.fl = fl; r.v = v; r.d = d; r.full = full;
        r.e_rdy = rdy; r.e_wr = wr; r.din_chk = dc; r.e_din = din;
        r.e_busy = bsy; r.e_cnt = cnt;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            if (nfail <= 40)
                $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic fl, input logic v,
                         input logic [31:0] d, input logic full);
        @(negedge clk_wr);
        rst_wr_n = rst; flush = fl; s_valid = v; s_data = d; fifo_full = full;
        #1;
    endtask

    task automatic chk_out(input string tag, input logic rdy, input logic wr,
                           input logic bsy, input logic [15:0] cnt);
        chk({tag, " s_ready"}, {31'd0, s_ready}, {31'd0, rdy});
        chk({tag, " fifo_write"}, {31'd0, fifo_write}, {31'd0, wr});
        chk({tag, " busy"}, {31'd0, busy}, {31'd0, bsy});
        chk({tag, " wr_count"}, {16'd0, wr_count}, {16'd0, cnt});
        chk({tag, " wr_count4"}, {28'd0, wr_count_n}, {28'd0, cnt[3:0]});
    endtask

    logic [31:0] q[$];
    int unsigned accepted;
    int unsigned mcount;
    logic        mready;
    logic        v_r, f_r, e_wr, push;
    logic [31:0] d_r;

    initial begin
        rst_wr_n = 1'b0; flush = 1'b0; s_valid = 1'b0; s_data = '0; fifo_full = 1'b0;
        void'($urandom(32'd20240611));
        repeat (2) @(posedge clk_wr);

        // Streaming 0..9
        tbl.push_back(mk(0,1,32'h0,0, 0,0,0,32'h0,0,16'd0));
        tbl.push_back(mk(0,1,32'h0,0, 1,0,0,32'h0,0,16'd0));
        for (int unsigned k = 1; k <= 9; k++)
            tbl.push_back(mk(0,1,k,0, 1,1,1,k-1,1,16'(k-1)));
        tbl.push_back(mk(0,0,32'h0,0, 1,1,1,32'h9,1,16'd9));
        tbl.push_back(mk(0,0,32'h0,0, 1,0,0,32'h0,0,16'd10));
        // Back-pressure: full during cycles 3..8 of the 0xA0 stream
        tbl.push_back(mk(0,1,32'hA0,0, 1,0,0,32'h0,0,16'd10));
        tbl.push_back(mk(0,1,32'hA1,0, 1,1,1,32'hA0,1,16'd10));
        tbl.push_back(mk(0,1,32'hA2,0, 1,1,1,32'hA1,1,16'd11));
        tbl.push_back(mk(0,1,32'hA3,1, 1,0,1,32'hA2,1,16'd12));
        for (int unsigned k = 0; k < 5; k++)
            tbl.push_back(mk(0,1,32'hA4,1, 0,0,1,32'hA2,1,16'd12));
        tbl.push_back(mk(0,1,32'hA4,0, 0,1,1,32'hA2,1,16'd12));
        tbl.push_back(mk(0,1,32'hA4,0, 1,1,1,32'hA3,1,16'd13));
        tbl.push_back(mk(0,1,32'hA5,0, 1,1,1,32'hA4,1,16'd14));
        tbl.push_back(mk(0,0,32'h0,0, 1,1,1,32'hA5,1,16'd15));
        tbl.push_back(mk(0,0,32'h0,0, 1,0,0,32'h0,0,16'd16));
        // Flush with two beats buffered, then a flush that swallows a handshake
        tbl.push_back(mk(0,1,32'hB0,1, 1,0,0,32'h0,0,16'd16));
        tbl.push_back(mk(0,1,32'hB1,1, 1,0,1,32'hB0,1,16'd16));
        tbl.push_back(mk(0,0,32'h0,1, 0,0,1,32'hB0,1,16'd16));
        tbl.push_back(mk(1,0,32'h0,0, 0,0,0,32'h0,1,16'd16));
        tbl.push_back(mk(0,0,32'h0,0, 0,0,0,32'h0,0,16'd16));
        tbl.push_back(mk(0,1,32'hC0,0, 1,0,0,32'h0,0,16'd16));
        tbl.push_back(mk(0,0,32'h0,0, 1,1,1,32'hC0,1,16'd16));
        tbl.push_back(mk(0,0,32'h0,0, 1,0,0,32'h0,0,16'd17));
        tbl.push_back(mk(1,1,32'hD0,0, 1,0,0,32'h0,0,16'd17));
        tbl.push_back(mk(0,1,32'hD1,0, 0,0,0,32'h0,0,16'd17));
        tbl.push_back(mk(0,1,32'hD1,0, 1,0,0,32'h0,0,16'd17));
        tbl.push_back(mk(0,0,32'h0,0, 1,1,1,32'hD1,1,16'd17));
        tbl.push_back(mk(0,0,32'h0,0, 1,0,0,32'h0,0,16'd18));

        foreach (tbl[i]) begin
            drive(1'b1, tbl[i].fl, tbl[i].v, tbl[i].d, tbl[i].full);
            chk_out($sformatf("vec%0d", i), tbl[i].e_rdy, tbl[i].e_wr, tbl[i].e_busy, tbl[i].e_cnt);
            if (tbl[i].din_chk)
                chk($sformatf("vec%0d fifo_din", i), fifo_din, tbl[i].e_din);
        end

        // Reset mid-stream for two cycles
        drive(1, 0, 1, 32'hE0, 0); chk_out("rs0", 1, 0, 0, 16'd18);
        drive(1, 0, 1, 32'hE1, 0); chk_out("rs1", 1, 1, 1, 16'd18);
        chk("rs1 fifo_din", fifo_din, 32'hE0);
        drive(0, 0, 1, 32'hE2, 0); chk_out("rs2", 1, 1, 1, 16'd19);
        chk("rs2 fifo_din", fifo_din, 32'hE1);
        drive(0, 0, 1, 32'hE2, 0); chk_out("rs3", 0, 0, 0, 16'd0);
        drive(1, 0, 1, 32'hF0, 0); chk_out("rs4", 0, 0, 0, 16'd0);
        drive(1, 0, 1, 32'hF0, 0); chk_out("rs5", 1, 0, 0, 16'd0);
        drive(1, 0, 0, 32'h0, 0);  chk_out("rs6", 1, 1, 1, 16'd0);
        chk("rs6 fifo_din", fifo_din, 32'hF0);
        drive(1, 0, 0, 32'h0, 0);  chk_out("rs7", 1, 0, 0, 16'd1);

        // Randomized valid/full against a scoreboard, followed by a drain
        drive(0, 0, 0, 32'h0, 0);
        drive(0, 0, 0, 32'h0, 0);
        accepted = 0; mcount = 0; mready = 1'b0;
        for (int unsigned c = 0; c < 10008; c++) begin
            if (c < 10000) begin
                v_r = ($urandom_range(0, 3) != 0);
                f_r = ($urandom_range(0, 2) == 0);
                d_r = $urandom;
            end else begin
                v_r = 1'b0; f_r = 1'b0; d_r = '0;
            end
            @(negedge clk_wr);
            rst_wr_n = 1'b1; flush = 1'b0; s_valid = v_r; fifo_full = f_r;
            s_data = v_r ? d_r : 'x;
            #1;
            e_wr = (mcount != 0) && !f_r;
            push = v_r && mready;
            chk("rnd s_ready", {31'd0, s_ready}, {31'd0, mready});
            chk("rnd fifo_write", {31'd0, fifo_write}, {31'd0, e_wr});
            chk("rnd busy", {31'd0, busy}, {31'd0, (mcount != 0)});
            if (e_wr) begin
                if (q.size() == 0) begin
                    chk("rnd scoreboard empty", 32'd0, 32'd1);
                end else begin
                    chk("rnd fifo_din", fifo_din, q[0]);
                    void'(q.pop_front());
                end
            end
            if (push) begin
                q.push_back(d_r);
                accepted++;
            end
            mcount = mcount + (push ? 1 : 0) - (e_wr ? 1 : 0);
            mready = (mcount < 2);
        end
        chk("rnd leftover beats", q.size(), 32'd0);
        chk("rnd wr_count", {16'd0, wr_count}, {16'd0, accepted[15:0]});
        chk("rnd wr_count4", {28'd0, wr_count_n}, {28'd0, accepted[3:0]});

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
